conv_window_ctrl: RTL and testbench

- Line-buffer controller and sequencer in front of the 3x3 convolution datapath.
- Accepts the 8-bit grey pixel stream and stores it in four rotating line buffers.
- Once three full lines are held, emits one 72-bit 3x3 window per cycle, with a matching valid strobe and a frame-stable opcode.
- Sits between the capture/greyscale stage and the convolution unit.

---
 rtl/conv_window_ctrl_if.sv | 30 +++
 rtl/conv_window_ctrl.sv | 166 ++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/conv_window_ctrl_if.sv
// conv_window_ctrl_if
//   Pixel-stream input and 3x3 window output bundle for conv_window_ctrl.
//   master : upstream capture stage / convolution side (drives i_*, sees o_*)
//   slave  : conv_window_ctrl (sees i_*, drives o_*)
//   i_pixel_data[7:0]   grey pixel          o_pixel_data[71:0]  3x3 window, byte 3*r+k
//   i_pixel_data_valid  pixel qualifier     o_pixel_data_valid  window qualifier
//   i_frame_start       first pixel flag    o_opcode[3:0]       opcode for current line
//   i_opcode[3:0]       requested opcode    o_line_done         last window of a line
//                                           o_overflow          sticky overrun flag
interface conv_window_ctrl_if;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_data_valid;
    logic        i_frame_start;
    logic [3:0]  i_opcode;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic [3:0]  o_opcode;
    logic        o_line_done;
    logic        o_overflow;

    modport master (
        output i_pixel_data, i_pixel_data_valid, i_frame_start, i_opcode,
        input  o_pixel_data, o_pixel_data_valid, o_opcode, o_line_done, o_overflow
    );

    modport slave (
        input  i_pixel_data, i_pixel_data_valid, i_frame_start, i_opcode,
        output o_pixel_data, o_pixel_data_valid, o_opcode, o_line_done, o_overflow
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
//   Line-buffer controller for the 3x3 convolution datapath. Pixels are written
//   into four rotating line buffers; once three lines are held, one 3x3 window
//   per cycle is issued for a whole line, with horizontal border replication.
//   Ports:
//     i_clk  system clock, rising edge
//     i_rst  synchronous active-high reset
//     bus    conv_window_ctrl_if.slave (pixel stream in, window stream out)
//   Parameters: IMG_WIDTH (pixels per line, >= 3), CW (column counter width).
//   Build option: CONV_WINDOW_CTRL_OPCODE_FILTER_EN restricts which frame-start
//   opcodes are accepted into the shadow register.
//
//   state | meaning
//   IDLE  | waiting for three buffered lines
//   READ  | issuing one window per cycle across the current line
module conv_window_ctrl #(
    parameter int IMG_WIDTH = 640,
    parameter int CW        = 10
) (
    input logic               i_clk,
    input logic               i_rst,
    conv_window_ctrl_if.slave bus
);
    localparam int            OW        = $clog2(4 * IMG_WIDTH + 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [OW-1:0] OCC_LINE  = OW'(IMG_WIDTH);
    localparam logic [OW-1:0] OCC_START = OW'(3 * IMG_WIDTH);
    localparam logic [OW-1:0] OCC_FULL  = OW'(4 * IMG_WIDTH);
    localparam logic [3:0]    OPC_RESET = 4'b1000;

    typedef enum logic {IDLE, READ} state_t;
    state_t state, state_nxt;

    logic [7:0]    lb [4][IMG_WIDTH];
    logic [1:0]    wr_lb, rd_lb;
    logic [CW-1:0] wr_col, rd_col;
    logic [OW-1:0] occ, occ_inc, occ_nxt;
    logic [3:0]    opc_shadow, opc_load;

    logic          frame_start, pix_in, issue, line_cmp, start_rd, ovf_hit, wr_en;
    logic [CW-1:0] col_l, col_r;
    logic [71:0]   win;

    assign frame_start = bus.i_frame_start & bus.i_pixel_data_valid;
    assign pix_in      = bus.i_pixel_data_valid & ~bus.i_frame_start;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        line_cmp  = 1'b0;
        start_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (occ >= OCC_START) begin
                    state_nxt = READ;
                    start_rd  = 1'b1;
                end
            end
            READ: begin
                issue = 1'b1;
                if (rd_col == COL_LAST) begin
                    line_cmp  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A new frame discards whatever was being read.
        if (frame_start) begin
            state_nxt = IDLE;
            issue     = 1'b0;
            line_cmp  = 1'b0;
            start_rd  = 1'b0;
        end
    end

    // A full buffer can still take a pixel if a line drains in the same cycle.
    assign ovf_hit = pix_in & (occ == OCC_FULL) & ~line_cmp;
    assign wr_en   = pix_in & ~ovf_hit;
    assign occ_inc = occ + OW'(wr_en);
    assign occ_nxt = line_cmp ? occ_inc - OCC_LINE : occ_inc;

    always_comb begin
`ifdef CONV_WINDOW_CTRL_OPCODE_FILTER_EN
        case (bus.i_opcode)
            4'b1000, 4'b1001, 4'b0011, 4'b1101: opc_load = bus.i_opcode;
            default:                            opc_load = opc_shadow;
        endcase
`else
        opc_load = bus.i_opcode;
`endif
    end

    // Edge columns replicate the border pixel.
    assign col_l = (rd_col == '0)       ? '0       : rd_col - 1'b1;
    assign col_r = (rd_col == COL_LAST) ? COL_LAST : rd_col + 1'b1;

    always_comb begin
        win = '0;
        for (int r = 0; r < 3; r++) begin
            win[(3*r+0)*8 +: 8] = lb[rd_lb + 2'(r)][col_l];
            win[(3*r+1)*8 +: 8] = lb[rd_lb + 2'(r)][rd_col];
            win[(3*r+2)*8 +: 8] = lb[rd_lb + 2'(r)][col_r];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (frame_start) lb[2'd0][{CW{1'b0}}] <= bus.i_pixel_data;
            else if (wr_en)  lb[wr_lb][wr_col]    <= bus.i_pixel_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_pixel_data       <= '0;
            bus.o_pixel_data_valid <= 1'b0;
            bus.o_line_done        <= 1'b0;
            bus.o_overflow         <= 1'b0;
            bus.o_opcode           <= OPC_RESET;
            opc_shadow             <= OPC_RESET;
            wr_lb                  <= '0;
            wr_col                 <= '0;
            rd_lb                  <= '0;
            rd_col                 <= '0;
            occ                    <= '0;
        end else begin
            bus.o_pixel_data_valid <= issue;
            bus.o_line_done        <= line_cmp;
            if (issue)    bus.o_pixel_data <= win;
            if (ovf_hit)  bus.o_overflow   <= 1'b1;
            if (start_rd) bus.o_opcode     <= opc_shadow;
            if (frame_start) begin
                wr_lb      <= '0;
                wr_col     <= CW'(1);
                occ        <= OW'(1);
                rd_lb      <= '0;
                rd_col     <= '0;
                opc_shadow <= opc_load;
            end else begin
                occ <= occ_nxt;
                if (wr_en) begin
                    if (wr_col == COL_LAST) begin
                        wr_col <= '0;
                        wr_lb  <= wr_lb + 1'b1;
                    end else begin
                        wr_col <= wr_col + 1'b1;
                    end
                end
                if (issue) begin
                    if (rd_col == COL_LAST) begin
                        rd_col <= '0;
                        rd_lb  <= rd_lb + 1'b1;
                    end else begin
                        rd_col <= rd_col + 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl
//   Directed bench for conv_window_ctrl with IMG_WIDTH=8. Edge t is the t-th
//   rising edge after stimulus starts; pixel t of a stream is written on edge t
//   and outputs are sampled 1 time unit after each edge.
module tb_conv_window_ctrl;
    localparam int W = 8;

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;

    conv_window_ctrl_if bus();

    conv_window_ctrl #(.IMG_WIDTH(W), .CW(3)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [71:0] pk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7, b8);
        return {b8, b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    task automatic step(input logic v, input logic fs, input logic [7:0] pix, input logic [3:0] opc);
        bus.i_pixel_data_valid = v;
        bus.i_frame_start      = fs;
        bus.i_pixel_data       = pix;
        bus.i_opcode           = opc;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step(1'b0, 1'b0, 8'd0, 4'b0000);
        step(1'b0, 1'b0, 8'd0, 4'b0000);
        i_rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_data"},   bus.o_pixel_data,       72'd0);
        chk({tag, "_valid"},  bus.o_pixel_data_valid, 1'b0);
        chk({tag, "_done"},   bus.o_line_done,        1'b0);
        chk({tag, "_ovf"},    bus.o_overflow,         1'b0);
        chk({tag, "_opcode"}, bus.o_opcode,           4'b1000);
    endtask

    logic exp_v;

    initial begin
        bus.i_pixel_data       = 8'd0;
        bus.i_pixel_data_valid = 1'b0;
        bus.i_frame_start      = 1'b0;
        bus.i_opcode           = 4'b0000;

        // Reset state
        do_reset();
        chk_reset_state("rst");

        // Two output lines from a 4-line stream; opcode changes mid-frame
        for (int t = 0; t <= 45; t++) begin
            if (t <= 31) step(1'b1, t == 0, 8'(t), (t == 0) ? 4'b1001 : 4'b0011);
            else         step(1'b0, 1'b0, 8'd0, 4'b0011);
            exp_v = (t >= 25 && t <= 32) || (t >= 34 && t <= 41);
            chk("l_valid",  bus.o_pixel_data_valid, exp_v);
            chk("l_done",   bus.o_line_done, (t == 32) || (t == 41));
            chk("l_opcode", bus.o_opcode, (t >= 24) ? 4'b1001 : 4'b1000);
            chk("l_ovf",    bus.o_overflow, 1'b0);
            if (t == 25) chk("win_l0_c0", bus.o_pixel_data, pk(0, 0, 1, 8, 8, 9, 16, 16, 17));
            if (t == 29) chk("win_l0_c4", bus.o_pixel_data, pk(3, 4, 5, 11, 12, 13, 19, 20, 21));
            if (t == 32) chk("win_l0_c7", bus.o_pixel_data, pk(6, 7, 7, 14, 15, 15, 22, 23, 23));
            if (t == 34) chk("win_l1_c0", bus.o_pixel_data, pk(8, 8, 9, 16, 16, 17, 24, 24, 25));
            if (t == 41) chk("win_l1_c7", bus.o_pixel_data, pk(14, 15, 15, 22, 23, 23, 30, 31, 31));
        end

        // Overflow: an unbroken stream outpaces the 8-of-9 read rate. Occupancy
        // is 25 after edge 32, climbs to 32 by edge 39, and the write on edge 40
        // lands while full with the line completion still one edge away.
        do_reset();
        for (int t = 0; t <= 45; t++) begin
            step(1'b1, t == 0, 8'(t), 4'b1000);
            chk("ovf_flag", bus.o_overflow, t >= 40);
            chk("ovf_done", bus.o_line_done, (t == 32) || (t == 41));
        end
        for (int t = 0; t < 4; t++) begin
            step(1'b0, 1'b0, 8'd0, 4'b1000);
            chk("ovf_sticky", bus.o_overflow, 1'b1);
        end
        // Reset in mid-stream clears everything on the next edge
        i_rst = 1'b1;
        step(1'b1, 1'b0, 8'hAA, 4'b1001);
        chk_reset_state("mid_rst");
        i_rst = 1'b0;

        // Frame start while issuing column 4 of the first line
        do_reset();
        for (int t = 0; t <= 55; t++) begin
            if (t <= 28)      step(1'b1, t == 0, 8'(t), 4'b1001);
            else if (t <= 52) step(1'b1, t == 29, 8'(100 + t - 29), 4'b1001);
            else              step(1'b0, 1'b0, 8'd0, 4'b1001);
            exp_v = (t >= 25 && t <= 28) || (t >= 54);
            chk("fs_valid", bus.o_pixel_data_valid, exp_v);
            chk("fs_done",  bus.o_line_done, 1'b0);
            if (t == 54) chk("fs_win", bus.o_pixel_data, pk(100, 100, 101, 108, 108, 109, 116, 116, 117));
        end

        // Frame-start opcode acceptance
        do_reset();
        for (int t = 0; t <= 25; t++) begin
            if (t <= 23) step(1'b1, t == 0, 8'(t), 4'b1101);
            else         step(1'b0, 1'b0, 8'd0, 4'b1101);
        end
        chk("opc_first", bus.o_opcode, 4'b1101);
        for (int t = 0; t <= 25; t++) begin
            if (t <= 23) step(1'b1, t == 0, 8'(t), 4'b0111);
            else         step(1'b0, 1'b0, 8'd0, 4'b0111);
            if (t == 23) chk("opc_hold", bus.o_opcode, 4'b1101);
        end
`ifdef CONV_WINDOW_CTRL_OPCODE_FILTER_EN
        chk("opc_second", bus.o_opcode, 4'b1101);
`else
        chk("opc_second", bus.o_opcode, 4'b0111);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
